// File: rtl/multi_spi_pkg.sv
// Shared lane-mode encodings and helpers for the multi-lane SPI word receiver.
package multi_spi_pkg;

    localparam logic [1:0] MODE_X1   = 2'b00;
    localparam logic [1:0] MODE_X2   = 2'b01;
    localparam logic [1:0] MODE_X4   = 2'b11;
    localparam logic [1:0] MODE_RSVD = 2'b10;

    // Bits consumed per accepted strobe; reserved mode consumes nothing.
    function automatic logic [2:0] mode_step(input logic [1:0] mode);
        case (mode)
            MODE_X1: mode_step = 3'd1;
            MODE_X2: mode_step = 3'd2;
            MODE_X4: mode_step = 3'd4;
            default: mode_step = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/spi_word_fifo.sv
// Pointer-plus-count output FIFO holding completed receive words.
module spi_word_fifo #(
    parameter int unsigned REGSIZE = 8,
    parameter int unsigned DEPTH   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic [REGSIZE-1:0] push_data,
    input  logic               pop,
    output logic [REGSIZE-1:0] head_data,
    output logic               empty,
    output logic               full
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [REGSIZE-1:0] mem [DEPTH];
    logic [AW-1:0]      rd_ptr;
    logic [AW-1:0]      wr_ptr;
    logic [CW-1:0]      count;
    logic               do_pop;
    logic               do_push;

    assign empty     = (count == CW'(0));
    assign full      = (count == CW'(DEPTH));
    assign do_pop    = pop && !empty;
    // A full FIFO still takes a word when the head leaves in the same cycle.
    assign do_push   = push && (!full || do_pop);
    assign head_data = mem[rd_ptr];

    // Storage, pointers and occupancy; storage is cleared so the head reads 0 after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/multi_spi_word_rx.sv
// Assembles 1/2/4-lane SPI samples into REGSIZE-bit words and queues them for the consumer.
module multi_spi_word_rx
    import multi_spi_pkg::*;
#(
    parameter int unsigned REGSIZE = 8,
    parameter int unsigned DEPTH   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cs_n,
    input  logic               strobe,
    input  logic [3:0]         I,
    input  logic [1:0]         S,
    output logic [REGSIZE-1:0] out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               frame_abort,
    output logic               overflow,
    output logic               mode_err
);

    localparam int unsigned CW = $clog2(REGSIZE + 1);

    logic [1:0]         mode_q;
    logic [REGSIZE-1:0] shreg;
    logic [REGSIZE-1:0] shreg_nxt;
    logic [CW-1:0]      bitcnt;
    logic [CW-1:0]      bitcnt_nxt;
    logic               cs_n_q;
    logic               accept;
    logic               word_done;
    logic               pop;
    logic               fifo_empty;
    logic               fifo_full;

    assign accept     = strobe && !cs_n && (mode_q != MODE_RSVD);
    assign bitcnt_nxt = bitcnt + CW'(mode_step(mode_q));
    assign word_done  = accept && (bitcnt_nxt == CW'(REGSIZE));
    assign out_valid  = !fifo_empty;
    assign pop        = out_valid && out_ready;

    // Shift the sampled lanes in at the LSB end so the earliest bits land in the MSBs.
    always_comb begin
        shreg_nxt = shreg;
        case (mode_q)
            MODE_X1: shreg_nxt = {shreg[REGSIZE-2:0], I[0]};
            MODE_X2: shreg_nxt = {shreg[REGSIZE-3:0], I[1:0]};
            MODE_X4: shreg_nxt = {shreg[REGSIZE-5:0], I[3:0]};
            default: shreg_nxt = shreg;
        endcase
    end

    // Mode capture, bit accumulation, frame-end detection and sticky error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q      <= MODE_X1;
            shreg       <= '0;
            bitcnt      <= '0;
            cs_n_q      <= 1'b1;
            frame_abort <= 1'b0;
            overflow    <= 1'b0;
            mode_err    <= 1'b0;
        end else begin
            cs_n_q      <= cs_n;
            frame_abort <= 1'b0;
            if (cs_n) begin
                mode_q <= S;
                if (!cs_n_q) begin
                    frame_abort <= (bitcnt != CW'(0));
                    bitcnt      <= '0;
                    shreg       <= '0;
                end
            end else begin
                if (mode_q == MODE_RSVD) begin
                    mode_err <= 1'b1;
                end
                if (accept) begin
                    shreg  <= shreg_nxt;
                    bitcnt <= word_done ? CW'(0) : bitcnt_nxt;
                end
            end
            if (word_done && fifo_full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    spi_word_fifo #(
        .REGSIZE(REGSIZE),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (word_done),
        .push_data(shreg_nxt),
        .pop      (pop),
        .head_data(out_data),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

endmodule

// File: tb/tb_multi_spi_word_rx.sv
// Scoreboard bench: stimulus queues expected words, a negedge monitor checks each handshake.
module tb_multi_spi_word_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       cs_n;
    logic       strobe;
    logic [3:0] I;
    logic [1:0] S;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       frame_abort;
    logic       overflow;
    logic       mode_err;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    multi_spi_word_rx #(.REGSIZE(8), .DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .cs_n       (cs_n),
        .strobe     (strobe),
        .I          (I),
        .S          (S),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .frame_abort(frame_abort),
        .overflow   (overflow),
        .mode_err   (mode_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted word must match the oldest expected word.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got 0x%0h, expected none", out_data);
            end else begin
                check("word", 32'(out_data), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic open_frame(input logic [1:0] mode);
        cs_n = 1'b1;
        S    = mode;
        tick();
        cs_n = 1'b0;
    endtask

    task automatic close_frame();
        strobe = 1'b0;
        cs_n   = 1'b1;
        tick();
        tick();
    endtask

    task automatic send(input logic [3:0] lanes);
        strobe = 1'b1;
        I      = lanes;
        tick();
        strobe = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
        tick();
        check({name, "_empty"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [7:0] x1_bits;
        int aborts;
        rst = 1'b1; cs_n = 1'b1; strobe = 1'b0; I = 4'h0; S = 2'b00; out_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
        check("rst_valid", 32'(out_valid), 0);
        check("rst_data", 32'(out_data), 0);
        check("rst_abort", 32'(frame_abort), 0);
        check("rst_ovf", 32'(overflow), 0);
        check("rst_moderr", 32'(mode_err), 0);

        // X1 word 0xA5, bits MSB first on I[0]
        x1_bits = 8'hA5;
        open_frame(2'b00);
        for (int i = 7; i >= 1; i--) send({3'b000, x1_bits[i]});
        check("x1_not_yet", 32'(out_valid), 0);
        exp_q.push_back(8'hA5);
        send({3'b000, x1_bits[0]});
        check("x1_latency", 32'(out_valid), 1);
        check("x1_data", 32'(out_data), 32'h00A5);
        close_frame();
        drain("x1");

        // X4 back-to-back: 3,C,5,A
        open_frame(2'b11);
        send(4'h3);
        exp_q.push_back(8'h3C);
        send(4'hC);
        check("x4_first_valid", 32'(out_valid), 1);
        send(4'h5);
        exp_q.push_back(8'h5A);
        send(4'hA);
        check("x4_second_valid", 32'(out_valid), 1);
        check("x4_second_data", 32'(out_data), 32'h005A);
        close_frame();
        drain("x4");

        // Mode freeze: X2 frame, S moves to 11 mid-frame
        open_frame(2'b01);
        send(4'b0011);
        S = 2'b11;
        send(4'b1100);
        send(4'b0110);
        exp_q.push_back(8'hC9);
        send(4'b1001);
        close_frame();
        drain("freeze");

        // Abort after 5 single-lane strobes
        open_frame(2'b00);
        for (int i = 0; i < 5; i++) send(4'h1);
        strobe = 1'b1;
        cs_n   = 1'b1;
        aborts = 0;
        tick();
        strobe = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (frame_abort) aborts++;
            tick();
        end
        check("abort_pulses", 32'(aborts), 1);
        check("abort_nowrite", 32'(out_valid), 0);
        x1_bits = 8'h3E;
        open_frame(2'b00);
        exp_q.push_back(8'h3E);
        for (int i = 7; i >= 0; i--) send({3'b000, x1_bits[i]});
        close_frame();
        check("after_abort_clean", 32'(frame_abort), 0);
        drain("abort");

        // Overflow: five quad words with consumer stalled
        check("ovf_before", 32'(overflow), 0);
        out_ready = 1'b0;
        open_frame(2'b11);
        for (int w = 1; w <= 5; w++) begin
            if (w <= 4) exp_q.push_back(8'(w * 8'h11));
            send(4'(w));
            send(4'(w));
        end
        check("ovf_set", 32'(overflow), 1);
        check("ovf_head", 32'(out_data), 32'h0011);
        close_frame();
        check("ovf_head_stable", 32'(out_data), 32'h0011);
        out_ready = 1'b1;
        drain("ovf");
        check("ovf_sticky", 32'(overflow), 1);

        // Reserved mode frame
        open_frame(2'b10);
        for (int i = 0; i < 8; i++) send(4'hF);
        check("rsvd_err", 32'(mode_err), 1);
        check("rsvd_nowords", 32'(out_valid), 0);
        close_frame();
        check("rsvd_noabort", 32'(frame_abort), 0);

        // Reset mid-frame after two quad strobes
        open_frame(2'b11);
        send(4'hF);
        send(4'hF);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst2_valid", 32'(out_valid), 0);
        check("rst2_data", 32'(out_data), 0);
        check("rst2_ovf", 32'(overflow), 0);
        check("rst2_moderr", 32'(mode_err), 0);
        check("rst2_abort", 32'(frame_abort), 0);
        cs_n = 1'b1;
        tick();
        tick();
        check("rst2_noabort", 32'(frame_abort), 0);
        open_frame(2'b11);
        send(4'h1);
        exp_q.push_back(8'h12);
        send(4'h2);
        close_frame();
        drain("rst2");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_spi_word_rx.md
# multi_spi_word_rx

Downstream word-assembly stage for the multi-lane SPI receive path. Samples 1, 2 or 4 data lanes per strobe according to a per-frame lane mode, counts accumulated bits, and writes each completed REGSIZE-bit word into a small output FIFO. The FIFO drains over a valid/ready handshake to the register/command layer. The block also reports aborted frames and dropped words.

## Interface
Parameters:
- REGSIZE, 8, word width in bits; must be a multiple of 4 and at least 8.
- DEPTH, 4, output FIFO depth in words; must be a power of 2.

Ports:
- clk, input, 1, sole clock; all logic on its rising edge.
- rst, input, 1, synchronous, active-high reset.
- cs_n, input, 1, frame select, active low; high means idle.
- strobe, input, 1, one-cycle sample pulse; lanes are valid in this cycle.
- I, input, 4, data lanes; I[0] is the single-lane line.
- S, input, 2, lane mode: 00 = 1 lane, 01 = 2 lanes, 11 = 4 lanes, 10 = reserved.
- out_data, output, REGSIZE, FIFO head word.
- out_valid, output, 1, FIFO not empty.
- out_ready, input, 1, consumer accepts the head word.
- frame_abort, output, 1, one-cycle pulse when a frame ends with a partial word.
- overflow, output, 1, sticky; a completed word was dropped.
- mode_err, output, 1, sticky; a frame started in reserved mode.

## Operation
- **Mode capture.**
  - mode_q loads S on every cycle in which cs_n = 1.
  - mode_q is frozen while cs_n = 0, so changes on S mid-frame are ignored.
- **Sampling.**
  - A strobe is accepted only when cs_n = 0 and mode_q is not 10.
  - Strobes while cs_n = 1 are ignored.
- **Shift register.**
  - On an accepted strobe, shreg <= {shreg, lanes}, where lanes = I[0], I[1:0] or I[3:0] for mode 00, 01 or 11.
  - Earliest bits end up in the MSBs.
  - bitcnt increments by 1, 2 or 4.
- **Word complete.**
  - When bitcnt + step = REGSIZE, the new shreg value is pushed to the FIFO and bitcnt wraps to 0.
  - There is no intermediate state; a word is never split across modes.
- **Frame end.**
  - On the first cycle with cs_n = 1 after a cs_n = 0 cycle:
    - If bitcnt != 0, frame_abort pulses for one cycle, and bitcnt and shreg are cleared.
    - Partial bits are never pushed.
  - A strobe coinciding with the cs_n = 1 cycle is ignored.
- **Reserved mode.**
  - If mode_q = 10 during any cycle with cs_n = 0, mode_err is set.
  - All strobes in that frame are ignored.
- **FIFO.**
  - Push: a word completes.
  - Pop: out_valid && out_ready.
  - Full, with push and no pop: the word is dropped, overflow is set, and FIFO contents are unchanged.
  - Full, with push and pop in the same cycle: both succeed and the occupancy is unchanged.
  - Empty, with push: a same-cycle pop is impossible, since out_valid = 0.
  - Order is strictly first in, first out.
- **Reset values.**
  - out_valid = 0, out_data = 0, frame_abort = 0, overflow = 0, mode_err = 0.
  - Internal state is cleared: bitcnt = 0, shreg = 0, FIFO empty, mode_q = 00.
  - Reset mid-frame discards the partial word and FIFO contents, and does not pulse frame_abort.
  - Sticky flags clear only on rst.

## Timing
- **Latency.**
  - A word completes on the rising edge that samples its final strobe.
  - If the FIFO was empty, out_valid = 1 and out_data = the word in the following cycle (one-edge latency).
- **Output stability.** out_data is registered or FIFO-head; it is stable while out_valid = 1 and out_ready = 0.
- **Throughput.**
  - One strobe per cycle is accepted.
  - Quad mode with REGSIZE = 8 completes a word every 2 cycles; the FIFO sustains this with out_ready held at 1.
- **frame_abort timing.** frame_abort is asserted in the cycle after the first cs_n = 1 sample.
- **Sticky flag timing.** overflow and mode_err assert in the cycle after the triggering edge.

## Structure
- **Package multi_spi_pkg.**
  - Mode constants: MODE_X1 = 2'b00, MODE_X2 = 2'b01, MODE_X4 = 2'b11, MODE_RSVD = 2'b10.
  - Function mode_step(mode), returning the bit step: 1, 2, 4 or 0.
- **Sub-module spi_word_fifo.**
  - Parameters: width REGSIZE, depth DEPTH.
  - Ports: push, push_data, pop, head_data, empty, full.
  - Implementation: pointer-plus-count; no other sub-modules.
- **Top level** holds mode_q, shreg, bitcnt, the frame-end detect register (cs_n_q) and the sticky flags.

## Test plan
- **X1 word.** REGSIZE = 8, S = 00 at idle, cs_n low; 8 strobes with I[0] = 1,0,1,0,0,1,0,1 -> out_valid one cycle after the 8th strobe edge, out_data = 0xA5.
- **X4 back-to-back.** S = 11, strobes every cycle with nibbles 3,C,5,A, out_ready = 1 -> words 0x3C then 0x5A, no gaps beyond the mode rate.
- **Mode freeze.** Frame opens with S = 01; S switches to 11 after the first strobe; I[1:0] = 11,00,10,01 -> out_data = 0xC9 after the 4th strobe.
- **Abort.** S = 00, 5 strobes, then cs_n high -> frame_abort pulses once, no FIFO write; the next 8-strobe frame yields its own word, clean.
- **Overflow.** out_ready = 0, S = 11, 5 words 0x11..0x55 -> overflow = 1, FIFO holds 0x11..0x44; with out_ready = 1 they drain in that order, then out_valid = 0.
- **Reserved and reset.**
  - S = 10 frame with strobes -> mode_err = 1, no words.
  - rst pulsed mid-frame after 2 quad strobes -> all outputs 0; the next frame assembles from bit 0.
